// File: rtl/id_stage_if.sv
// Fetch/write-back/EX-facing bundle of the instruction decode stage.
// The slave side is the decode stage; the master side drives fetch and write-back traffic.
interface id_stage_if;
    logic [31:0] inst;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        PC_Write;
    logic        IR_Write;
    logic        ex_valid;
    logic        ex_illegal;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_branch;

    modport master (
        output inst, wb_we, wb_rd, wb_data, flush,
        input  PC_Write, IR_Write, ex_valid, ex_illegal, ex_rs1, ex_rs2, ex_rd,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_alu_op, ex_alu_src,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_branch
    );

    modport slave (
        input  inst, wb_we, wb_rd, wb_data, flush,
        output PC_Write, IR_Write, ex_valid, ex_illegal, ex_rs1, ex_rs2, ex_rd,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_alu_op, ex_alu_src,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_branch
    );
endinterface

// File: rtl/id_stage.sv
// RV32I-subset decode stage: register file with write-through bypass, decoder,
// load-use stall detection and a registered ID/EX pipeline entry.
module id_stage (
    input  logic       clk,
    input  logic       rst_n,
    id_stage_if.slave  bus
);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    logic [31:0] regs_r [32];

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [4:0]  rs1_s, rs2_s, rd_s;
    logic [31:0] rs1_data_s, rs2_data_s;
    logic [31:0] imm_s;
    logic [3:0]  alu_op_s;
    logic        alu_src_s, mem_read_s, mem_write_s, reg_write_s, branch_s;
    logic        uses_rs1_s, uses_rs2_s, illegal_s;
    logic        hazard_s, stall_s, issue_s, nxt_illegal_s;

    logic        ex_valid_r, ex_illegal_r;
    logic [4:0]  ex_rs1_r, ex_rs2_r, ex_rd_r;
    logic [31:0] ex_rs1_data_r, ex_rs2_data_r, ex_imm_r;
    logic [3:0]  ex_alu_op_r;
    logic        ex_alu_src_r, ex_mem_read_r, ex_mem_write_r, ex_reg_write_r, ex_branch_r;

    assign opcode_s = bus.inst[6:0];
    assign rd_s     = bus.inst[11:7];
    assign funct3_s = bus.inst[14:12];
    assign rs1_s    = bus.inst[19:15];
    assign rs2_s    = bus.inst[24:20];
    assign funct7_s = bus.inst[31:25];

    // Register file write port; x0 is never written and reset clears every entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (bus.wb_we && (bus.wb_rd != 5'd0)) begin
            regs_r[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Operand read with write-through bypass so a same-cycle write-back is seen.
    always_comb begin
        rs1_data_s = 32'd0;
        rs2_data_s = 32'd0;
        if (rs1_s == 5'd0) begin
            rs1_data_s = 32'd0;
        end else if (bus.wb_we && (bus.wb_rd == rs1_s)) begin
            rs1_data_s = bus.wb_data;
        end else begin
            rs1_data_s = regs_r[rs1_s];
        end
        if (rs2_s == 5'd0) begin
            rs2_data_s = 32'd0;
        end else if (bus.wb_we && (bus.wb_rd == rs2_s)) begin
            rs2_data_s = bus.wb_data;
        end else begin
            rs2_data_s = regs_r[rs2_s];
        end
    end

    // Instruction decoder: immediate, ALU operation, controls and legality.
    always_comb begin
        imm_s       = 32'd0;
        alu_op_s    = ALU_ADD;
        alu_src_s   = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        branch_s    = 1'b0;
        uses_rs1_s  = 1'b0;
        uses_rs2_s  = 1'b0;
        illegal_s   = 1'b0;
        case (opcode_s)
            OP_R: begin
                reg_write_s = 1'b1;
                uses_rs1_s  = 1'b1;
                uses_rs2_s  = 1'b1;
                if (funct7_s == 7'h00) begin
                    case (funct3_s)
                        3'd0:    alu_op_s = ALU_ADD;
                        3'd1:    alu_op_s = ALU_SLL;
                        3'd2:    alu_op_s = ALU_SLT;
                        3'd3:    alu_op_s = ALU_SLTU;
                        3'd4:    alu_op_s = ALU_XOR;
                        3'd5:    alu_op_s = ALU_SRL;
                        3'd6:    alu_op_s = ALU_OR;
                        3'd7:    alu_op_s = ALU_AND;
                        default: alu_op_s = ALU_ADD;
                    endcase
                end else if (funct7_s == 7'h20) begin
                    case (funct3_s)
                        3'd0:    alu_op_s  = ALU_SUB;
                        3'd5:    alu_op_s  = ALU_SRA;
                        default: illegal_s = 1'b1;
                    endcase
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OP_I: begin
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
                uses_rs1_s  = 1'b1;
                imm_s       = {{20{bus.inst[31]}}, bus.inst[31:20]};
                case (funct3_s)
                    3'd0:    alu_op_s = ALU_ADD;
                    3'd1:    alu_op_s = ALU_SLL;
                    3'd2:    alu_op_s = ALU_SLT;
                    3'd3:    alu_op_s = ALU_SLTU;
                    3'd4:    alu_op_s = ALU_XOR;
                    3'd5:    alu_op_s = bus.inst[30] ? ALU_SRA : ALU_SRL;
                    3'd6:    alu_op_s = ALU_OR;
                    3'd7:    alu_op_s = ALU_AND;
                    default: alu_op_s = ALU_ADD;
                endcase
            end
            OP_LW: begin
                mem_read_s  = 1'b1;
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
                uses_rs1_s  = 1'b1;
                imm_s       = {{20{bus.inst[31]}}, bus.inst[31:20]};
                illegal_s   = (funct3_s != 3'd2);
            end
            OP_SW: begin
                mem_write_s = 1'b1;
                alu_src_s   = 1'b1;
                uses_rs1_s  = 1'b1;
                uses_rs2_s  = 1'b1;
                imm_s       = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
                illegal_s   = (funct3_s != 3'd2);
            end
            OP_BEQ: begin
                branch_s   = 1'b1;
                alu_op_s   = ALU_SUB;
                uses_rs1_s = 1'b1;
                uses_rs2_s = 1'b1;
                imm_s      = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                              bus.inst[30:25], bus.inst[11:8], 1'b0};
                illegal_s  = (funct3_s != 3'd0);
            end
            OP_LUI: begin
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
                alu_op_s    = ALU_PASS_B;
                imm_s       = {bus.inst[31:12], 12'h000};
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // Load-use detection against the load currently sitting in ID/EX.
    always_comb begin
        hazard_s = 1'b0;
        if (ex_valid_r && ex_mem_read_r && (ex_rd_r != 5'd0)) begin
            hazard_s = ((ex_rd_r == rs1_s) && uses_rs1_s) ||
                       ((ex_rd_r == rs2_s) && uses_rs2_s);
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Flush overrides the stall; reset masks it so fetch is never frozen in reset.
    assign stall_s      = rst_n && hazard_s && !bus.flush;
    assign bus.PC_Write = !stall_s;
    assign bus.IR_Write = !stall_s;

    // Issue selection: priority flush > hazard > cleared word > illegal > real issue.
    always_comb begin
        issue_s       = 1'b0;
        nxt_illegal_s = 1'b0;
        if (bus.flush || hazard_s || (bus.inst == 32'd0)) begin
            issue_s       = 1'b0;
            nxt_illegal_s = 1'b0;
        end else if (illegal_s) begin
            issue_s       = 1'b0;
            nxt_illegal_s = 1'b1;
        end else begin
            issue_s       = 1'b1;
            nxt_illegal_s = 1'b0;
        end
    end

    // ID/EX pipeline register; bubbles drive every data field to zero.
    always_ff @(posedge clk) begin
        if (!rst_n || !issue_s) begin
            ex_valid_r     <= 1'b0;
            ex_illegal_r   <= rst_n ? nxt_illegal_s : 1'b0;
            ex_rs1_r       <= 5'd0;
            ex_rs2_r       <= 5'd0;
            ex_rd_r        <= 5'd0;
            ex_rs1_data_r  <= 32'd0;
            ex_rs2_data_r  <= 32'd0;
            ex_imm_r       <= 32'd0;
            ex_alu_op_r    <= 4'd0;
            ex_alu_src_r   <= 1'b0;
            ex_mem_read_r  <= 1'b0;
            ex_mem_write_r <= 1'b0;
            ex_reg_write_r <= 1'b0;
            ex_branch_r    <= 1'b0;
        end else begin
            ex_valid_r     <= 1'b1;
            ex_illegal_r   <= 1'b0;
            ex_rs1_r       <= rs1_s;
            ex_rs2_r       <= rs2_s;
            ex_rd_r        <= rd_s;
            ex_rs1_data_r  <= rs1_data_s;
            ex_rs2_data_r  <= rs2_data_s;
            ex_imm_r       <= imm_s;
            ex_alu_op_r    <= alu_op_s;
            ex_alu_src_r   <= alu_src_s;
            ex_mem_read_r  <= mem_read_s;
            ex_mem_write_r <= mem_write_s;
            ex_reg_write_r <= reg_write_s;
            ex_branch_r    <= branch_s;
        end
    end

    assign bus.ex_valid     = ex_valid_r;
    assign bus.ex_illegal   = ex_illegal_r;
    assign bus.ex_rs1       = ex_rs1_r;
    assign bus.ex_rs2       = ex_rs2_r;
    assign bus.ex_rd        = ex_rd_r;
    assign bus.ex_rs1_data  = ex_rs1_data_r;
    assign bus.ex_rs2_data  = ex_rs2_data_r;
    assign bus.ex_imm       = ex_imm_r;
    assign bus.ex_alu_op    = ex_alu_op_r;
    assign bus.ex_alu_src   = ex_alu_src_r;
    assign bus.ex_mem_read  = ex_mem_read_r;
    assign bus.ex_mem_write = ex_mem_write_r;
    assign bus.ex_reg_write = ex_reg_write_r;
    assign bus.ex_branch    = ex_branch_r;
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: each driven instruction pushes its expected ID/EX
// entry onto a scoreboard queue that is popped and compared after the clock edge.
module tb_id_stage;
    logic clk;
    logic rst_n;
    id_stage_if bus ();

    id_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [4:0]  ctrl;      // {reg_write, mem_read, mem_write, branch, alu_src}
        logic [3:0]  op;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step     = 0;

    localparam logic [31:0] I_ADD6  = 32'h00528333;
    localparam logic [31:0] I_ADDI1 = 32'h00A00093;
    localparam logic [31:0] I_LW2   = 32'h0000A103;
    localparam logic [31:0] I_ADD4  = 32'h00210233;
    localparam logic [31:0] I_BEQ   = 32'hFE208EE3;
    localparam logic [31:0] I_SRAI  = 32'h4020D193;
    localparam logic [31:0] I_LUI   = 32'h123452B7;
    localparam logic [31:0] I_SW    = 32'h0020A423;
    localparam logic [31:0] I_BADR  = 32'h40001033;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL step%0d %s: got 0x%08h, expected 0x%08h", step, tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic il, input logic [4:0] c,
                                input logic [3:0] op, input logic [31:0] imm,
                                input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2);
        exp_t e;
        e.valid = v; e.illegal = il; e.ctrl = c; e.op = op;
        e.imm = imm; e.rd = rd; e.d1 = d1; e.d2 = d2;
        return e;
    endfunction

    // One cycle: apply inputs, check fetch enables, clock, then score the ID/EX entry.
    task automatic drive(input logic r, input logic [31:0] i, input logic f,
                         input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic pcw, input exp_t e);
        exp_t got;
        step++;
        rst_n       = r;
        bus.inst    = i;
        bus.flush   = f;
        bus.wb_we   = we;
        bus.wb_rd   = wrd;
        bus.wb_data = wd;
        sb_q.push_back(e);
        #1;
        check_val("pc_write", {31'd0, bus.PC_Write}, {31'd0, pcw});
        check_val("ir_write", {31'd0, bus.IR_Write}, {31'd0, pcw});
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_val("valid",   {31'd0, bus.ex_valid},   {31'd0, got.valid});
        check_val("illegal", {31'd0, bus.ex_illegal}, {31'd0, got.illegal});
        check_val("ctrl", {27'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                           bus.ex_branch, bus.ex_alu_src}, {27'd0, got.ctrl});
        check_val("alu_op",  {28'd0, bus.ex_alu_op}, {28'd0, got.op});
        check_val("imm",     bus.ex_imm,             got.imm);
        check_val("rd",      {27'd0, bus.ex_rd},     {27'd0, got.rd});
        check_val("rs1_data", bus.ex_rs1_data,       got.d1);
        check_val("rs2_data", bus.ex_rs2_data,       got.d2);
    endtask

    initial begin
        exp_t bub;
        exp_t lw_e;
        bub  = mk(1'b0, 1'b0, 5'b00000, 4'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        lw_e = mk(1'b1, 1'b0, 5'b11001, 4'd0, 32'd0, 5'd2, 32'h100, 32'd0);

        // reset with write-back traffic that must be ignored
        drive(1'b0, 32'd0, 1'b0, 1'b1, 5'd7, 32'hDEAD, 1'b1, bub);
        drive(1'b0, 32'd0, 1'b0, 1'b1, 5'd7, 32'hDEAD, 1'b1, bub);
        // write x5, then read it twice through add x6,x5,x5
        drive(1'b1, 32'd0,  1'b0, 1'b1, 5'd5, 32'h1234, 1'b1, bub);
        drive(1'b1, I_ADD6, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1,
              mk(1'b1, 1'b0, 5'b10000, 4'd0, 32'd0, 5'd6, 32'h1234, 32'h1234));
        // x0 bypass must not leak wb_data
        drive(1'b1, I_ADDI1, 1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b1,
              mk(1'b1, 1'b0, 5'b10001, 4'd0, 32'd10, 5'd1, 32'd0, 32'd0));
        // lw with same-cycle bypass of x1, then dependent add stalls one cycle
        drive(1'b1, I_LW2,  1'b0, 1'b1, 5'd1, 32'h100, 1'b1, lw_e);
        drive(1'b1, I_ADD4, 1'b0, 1'b1, 5'd2, 32'hABCD, 1'b0, bub);
        drive(1'b1, I_ADD4, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1,
              mk(1'b1, 1'b0, 5'b10000, 4'd0, 32'd0, 5'd4, 32'hABCD, 32'hABCD));
        // same hazard, flushed in the stall cycle
        drive(1'b1, I_LW2,  1'b0, 1'b0, 5'd0, 32'd0, 1'b1, lw_e);
        drive(1'b1, I_ADD4, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, bub);
        // branch, illegal opcode, cleared word, illegal R encoding
        drive(1'b1, I_BEQ, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1,
              mk(1'b1, 1'b0, 5'b00010, 4'd1, 32'hFFFFFFFC, 5'd29, 32'h100, 32'hABCD));
        drive(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1,
              mk(1'b0, 1'b1, 5'b00000, 4'd0, 32'd0, 5'd0, 32'd0, 32'd0));
        drive(1'b1, 32'd0,  1'b0, 1'b0, 5'd0, 32'd0, 1'b1, bub);
        drive(1'b1, I_BADR, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1,
              mk(1'b0, 1'b1, 5'b00000, 4'd0, 32'd0, 5'd0, 32'd0, 32'd0));
        // srai, lui, sw
        drive(1'b1, I_SRAI, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1,
              mk(1'b1, 1'b0, 5'b10001, 4'd7, 32'h402, 5'd3, 32'h100, 32'hABCD));
        drive(1'b1, I_LUI, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1,
              mk(1'b1, 1'b0, 5'b10001, 4'd10, 32'h12345000, 5'd5, 32'd0, 32'd0));
        drive(1'b1, I_SW, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1,
              mk(1'b1, 1'b0, 5'b00101, 4'd0, 32'd8, 5'd8, 32'h100, 32'hABCD));
        // reset in the would-be stall cycle clears ID/EX and the register file
        drive(1'b1, I_LW2,  1'b0, 1'b0, 5'd0, 32'd0, 1'b1, lw_e);
        drive(1'b0, I_ADD4, 1'b0, 1'b1, 5'd2, 32'h777, 1'b1, bub);
        drive(1'b1, I_ADD4, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1,
              mk(1'b1, 1'b0, 5'b10000, 4'd0, 32'd0, 5'd4, 32'd0, 32'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode stage: consumes the 32-bit word presented by the fetch stage's instruction register, decodes the RV32I subset, reads a 32x32 register file and launches one ID/EX pipeline entry per cycle. Also detects load-use hazards and drives the `PC_Write`/`IR_Write` enables back to fetch. Accepts write-back traffic from the end of the pipeline and takes branch flushes from EX.

## Interface
- No parameters. Supported subset: R-ALU 0110011, I-ALU 0010011, LW 0000011, SW 0100011, BEQ 1100011, LUI 0110111.
- `clk`  in  1  rising-edge clock, single clock domain
- `rst_n`  in  1  synchronous, active-low reset
- `inst`  in  32  instruction word from fetch IR
- `wb_we`  in  1  register-file write enable
- `wb_rd`  in  5  write-back destination
- `wb_data`  in  32  write-back data
- `flush`  in  1  EX branch taken; kill the instruction being decoded
- `PC_Write`  out  1  fetch PC enable (comb., 0 = stall)
- `IR_Write`  out  1  fetch IR enable (comb., equals `PC_Write`)
- `ex_valid`  out  1  ID/EX entry holds a real instruction
- `ex_illegal`  out  1  entry was an illegal encoding (bubble issued)
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5 each  register indices
- `ex_rs1_data`, `ex_rs2_data`  out  32 each  operands
- `ex_imm`  out  32  sign-extended immediate
- `ex_alu_op`  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
- `ex_alu_src`  out  1  1 = operand B is `ex_imm`
- `ex_mem_read`, `ex_mem_write`, `ex_reg_write`, `ex_branch`  out  1 each  control

## Operation
- Register file: 32x32, x0 reads 0 and ignores writes. Write on rising `clk` when `wb_we`, `wb_rd`!=0. Same-cycle read of `wb_rd` returns `wb_data` (write-through bypass); no bypass for x0.
- Immediates: I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); U = {inst[31:12],12'h000}; R-type imm = 0.
- ALU op: R-type funct3 0→ADD/SUB (funct7[5]), 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL/SRA (funct7[5]), 6 OR, 7 AND. I-ALU same, but funct3 0 always ADD; funct3 5 uses inst[30]. LW/SW→ADD, BEQ→SUB, LUI→PASS_B.
- Controls: LW mem_read+reg_write+alu_src; SW mem_write+alu_src; BEQ branch; LUI reg_write+alu_src; I-ALU reg_write+alu_src; R-ALU reg_write.
- Illegal: unknown opcode; R-type funct7 not 0x00/0x20; funct7 0x20 with funct3 not 0/5; BEQ funct3!=0; LW/SW funct3!=2. Issue bubble with `ex_illegal`=1.
- `inst`==0x00000000 (cleared IM/IR): bubble, `ex_illegal`=0.
- Bubble = `ex_valid`, all controls, `ex_illegal`(unless illegal) 0; data fields don't-care but driven 0.
- Load-use hazard (comb.): `ex_valid` & `ex_mem_read` & `ex_rd`!=0 & ((`ex_rd`==rs1 & rs1 used) | (`ex_rd`==rs2 & rs2 used)). rs1 used by all but LUI; rs2 used by R, SW, BEQ.
- Hazard & !`flush`: `PC_Write`=`IR_Write`=0, bubble loaded into ID/EX; `inst` held by fetch and re-decoded next cycle.
- `flush`: bubble loaded, `PC_Write`=`IR_Write`=1; flush beats hazard and illegal.

## Timing
- Decode latency 1 cycle: `inst` at edge N appears on `ex_*` after edge N.
- Reset (`rst_n`=0 at an edge): all `ex_*` outputs 0, all 32 registers 0; `wb_we` ignored that edge. `PC_Write`/`IR_Write` read 1 during reset (no hazard possible).
- Stall lasts exactly one cycle per load-use (bubble clears `ex_mem_read`).
- Reset mid-stall: next cycle ID/EX is empty, enables return to 1.

## Test plan
- Reset then `wb_we`=1,`wb_rd`=5,`wb_data`=0x1234; next cycle `inst`=0x00528333 (add x6,x5,x5) → `ex_rs1_data`=`ex_rs2_data`=0x1234, `ex_alu_op`=0, `ex_reg_write`=1.
- Same-cycle bypass: `inst`=0x00A00093 (addi x1,x0,10) with `wb_rd`=0,`wb_data`=0xFFFF → `ex_rs1_data`=0, `ex_imm`=10, `ex_alu_src`=1.
- `inst`=0x0000A103 (lw x2,0(x1)) then 0x00210233 (add x4,x2,x2) → one cycle `PC_Write`=`IR_Write`=0, `ex_valid`=0; next cycle ADD issues, enables 1.
- Same hazard with `flush`=1 in stall cycle → enables 1, bubble, `ex_illegal`=0.
- `inst`=0xFE208EE3 (beq x1,x2,-4) → `ex_imm`=0xFFFFFFFC, `ex_branch`=1, `ex_alu_op`=1; `inst`=0xFFFFFFFF → `ex_illegal`=1, `ex_valid`=0; `inst`=0 → both 0.
- `inst`=0x4020D193 (srai x3,x1,2) → `ex_alu_op`=7, `ex_imm`=0x402; `inst`=0x123452B7 (lui x5) → `ex_imm`=0x12345000, `ex_alu_op`=10.
